// File: rtl/apb_timer_gen_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_timer_gen_pkg: register map, bit positions and TCR layout.      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package apb_timer_gen_pkg;

    localparam int ADDR_TDR  = 0;
    localparam int ADDR_TCR  = 1;
    localparam int ADDR_TSR  = 2;
    localparam int ADDR_TCNT = 3;
    localparam int ADDR_TCMP = 4;
    localparam int ADDR_TIER = 5;
    localparam int ADDR_LAST = 5;

    localparam int TCR_LOAD    = 7;
    localparam int TCR_ARE     = 6;
    localparam int TCR_DOWN    = 5;
    localparam int TCR_EN      = 4;
    localparam int TCR_OS      = 3;
    localparam int TCR_CKS_MSB = 2;
    localparam int TCR_CKS_LSB = 0;

    localparam int TSR_OVF   = 0;
    localparam int TSR_UNF   = 1;
    localparam int TSR_CMF   = 2;
    localparam int TSR_WIDTH = 3;

    // Stored TCR bits in register order; LOAD is a strobe and is not kept.
    typedef struct packed {
        logic       are;
        logic       down;
        logic       en;
        logic       os;
        logic [2:0] cks;
    } tcr_t;

    function automatic logic [6:0] cks_mask(input logic [2:0] cks);
        return 7'((8'd1 << cks) - 8'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | timer_prescaler: 7-bit free-running divider producing count ticks.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module timer_prescaler
    import apb_timer_gen_pkg::*;
(
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       en,
    input  logic       clr,
    input  logic [2:0] cks,
    output logic       tick
);

    logic [6:0] r_presc;
    logic [6:0] w_mask;

    assign w_mask = cks_mask(cks);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_presc <= 7'd0;
        end else if (!en || clr) begin
            r_presc <= 7'd0;
        end else begin
            r_presc <= r_presc + 7'd1;
        end
    end

    assign tick = en & ((r_presc & w_mask) == w_mask);

endmodule
`default_nettype wire

// File: rtl/apb_timer_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_timer_gen: APB up/down timer with prescaler, reload, compare.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module apb_timer_gen
    import apb_timer_gen_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  IRQ
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] r_tdr;
    logic [CNT_WIDTH-1:0] r_tcmp;
    logic [CNT_WIDTH-1:0] r_tcnt;
    tcr_t                 r_tcr;
    logic [TSR_WIDTH-1:0] r_tsr;
    logic [TSR_WIDTH-1:0] r_tier;
    logic                 r_cnt_upd;
    logic                 r_irq;

    logic                 w_access;
    logic                 w_err;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_load;
    logic                 w_tick;
    logic                 w_os_stop;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [TSR_WIDTH-1:0] w_set;

    assign w_access = PSEL & PENABLE;
    assign w_err    = w_access & ((PADDR > ADDR_WIDTH'(ADDR_LAST)) |
                                  (PWRITE & (PADDR == ADDR_WIDTH'(ADDR_TCNT))));
    assign w_wr     = w_access & PWRITE & ~w_err;
    assign w_rd     = w_access & ~PWRITE;
    assign w_load   = w_wr & (PADDR == ADDR_WIDTH'(ADDR_TCR)) & PWDATA[TCR_LOAD];

    assign PREADY  = 1'b1;
    assign PSLVERR = w_err;
    assign IRQ     = r_irq;

    timer_prescaler u_presc (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (r_tcr.en),
        .clr     (w_load),
        .cks     (r_tcr.cks),
        .tick    (w_tick)
    );

    // Load beats a tick; wrap events only come from ticks.
    always_comb begin
        w_cnt_nxt = r_tcnt;
        w_set     = '0;
        w_os_stop = 1'b0;
        if (w_load) begin
            w_cnt_nxt = r_tdr;
        end else if (w_tick) begin
            if (!r_tcr.down) begin
                if (r_tcnt == C_CNT_MAX) begin
                    w_set[TSR_OVF] = 1'b1;
                    w_cnt_nxt      = r_tcr.are ? r_tdr : '0;
                    w_os_stop      = r_tcr.os;
                end else begin
                    w_cnt_nxt = r_tcnt + CNT_WIDTH'(1);
                end
            end else begin
                if (r_tcnt == '0) begin
                    w_set[TSR_UNF] = 1'b1;
                    w_cnt_nxt      = r_tcr.are ? r_tdr : C_CNT_MAX;
                    w_os_stop      = r_tcr.os;
                end else begin
                    w_cnt_nxt = r_tcnt - CNT_WIDTH'(1);
                end
            end
        end
        // Compare looks at the value the counter took on the previous edge.
        w_set[TSR_CMF] = r_cnt_upd & (r_tcnt == r_tcmp);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_tdr     <= '0;
            r_tcmp    <= C_CNT_MAX;
            r_tcnt    <= '0;
            r_tcr     <= '0;
            r_tsr     <= '0;
            r_tier    <= '0;
            r_cnt_upd <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_tcnt    <= w_cnt_nxt;
            r_cnt_upd <= w_load | w_tick;
            r_irq     <= |(r_tsr & r_tier);

            if (w_wr && PADDR == ADDR_WIDTH'(ADDR_TDR)) begin
                r_tdr <= PWDATA[CNT_WIDTH-1:0];
            end
            if (w_wr && PADDR == ADDR_WIDTH'(ADDR_TCMP)) begin
                r_tcmp <= PWDATA[CNT_WIDTH-1:0];
            end
            if (w_wr && PADDR == ADDR_WIDTH'(ADDR_TIER)) begin
                r_tier <= PWDATA[TSR_WIDTH-1:0];
            end

            // An APB write of EN overrides the one-shot auto-clear.
            if (w_wr && PADDR == ADDR_WIDTH'(ADDR_TCR)) begin
                r_tcr <= tcr_t'(PWDATA[TCR_ARE:TCR_CKS_LSB]);
            end else if (w_os_stop) begin
                r_tcr.en <= 1'b0;
            end

            if (w_wr && PADDR == ADDR_WIDTH'(ADDR_TSR)) begin
                r_tsr <= (r_tsr & ~PWDATA[TSR_WIDTH-1:0]) | w_set;
            end else begin
                r_tsr <= r_tsr | w_set;
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (PADDR)
                ADDR_WIDTH'(ADDR_TDR):  PRDATA = DATA_WIDTH'(r_tdr);
                ADDR_WIDTH'(ADDR_TCR):  PRDATA = DATA_WIDTH'(r_tcr);
                ADDR_WIDTH'(ADDR_TSR):  PRDATA = DATA_WIDTH'(r_tsr);
                ADDR_WIDTH'(ADDR_TCNT): PRDATA = DATA_WIDTH'(r_tcnt);
                ADDR_WIDTH'(ADDR_TCMP): PRDATA = DATA_WIDTH'(r_tcmp);
                ADDR_WIDTH'(ADDR_TIER): PRDATA = DATA_WIDTH'(r_tier);
                default:                PRDATA = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_timer_gen: directed + random bench with a cycle-level model. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_apb_timer_gen;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [7:0] PRDATA;
    logic       IRQ;

    int checks   = 0;
    int failures = 0;

    // Reference model state, in plain integers.
    int m_tdr, m_tcmp, m_tcnt, m_tsr, m_tier, m_cks, m_presc;
    bit m_are, m_down, m_en, m_os, m_upd, m_irq;

    apb_timer_gen #(.CNT_WIDTH(8), .DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PRDATA  (PRDATA),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tdr = 0; m_tcmp = 255; m_tcnt = 0; m_tsr = 0; m_tier = 0; m_cks = 0;
        m_presc = 0; m_are = 0; m_down = 0; m_en = 0; m_os = 0; m_upd = 0; m_irq = 0;
    endtask

    function automatic int model_rd(input int a);
        case (a)
            0: return m_tdr;
            1: return (int'(m_are) << 6) | (int'(m_down) << 5) | (int'(m_en) << 4) |
                      (int'(m_os) << 3) | m_cks;
            2: return m_tsr;
            3: return m_tcnt;
            4: return m_tcmp;
            5: return m_tier;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_err(input int a, input bit w);
        return (a > 5) || (w && a == 3);
    endfunction

    // Advance one clock: derive next model state from the spec rules, then compare IRQ.
    task automatic cycle();
        int a, period, set, cnt, n_presc, n_tsr;
        bit acc, err, wr, tick, load, stop, n_en, n_irq, n_upd;
        a      = int'(PADDR);
        acc    = PSEL && PENABLE;
        err    = acc && model_err(a, PWRITE);
        wr     = acc && PWRITE && !err;
        period = 1 << m_cks;
        tick   = m_en && ((m_presc % period) == period - 1);
        load   = wr && (a == 1) && PWDATA[7];
        set    = (m_upd && m_tcnt == m_tcmp) ? 4 : 0;
        cnt    = m_tcnt;
        stop   = 0;
        if (load) begin
            cnt = m_tdr;
        end else if (tick) begin
            if (!m_down) begin
                if (m_tcnt == 255) begin
                    set |= 1; cnt = m_are ? m_tdr : 0; stop = m_os;
                end else cnt = m_tcnt + 1;
            end else begin
                if (m_tcnt == 0) begin
                    set |= 2; cnt = m_are ? m_tdr : 255; stop = m_os;
                end else cnt = m_tcnt - 1;
            end
        end
        n_en = m_en;
        if (wr && a == 1) n_en = PWDATA[4];
        else if (stop)    n_en = 0;
        n_presc = (!m_en || load) ? 0 : (m_presc + 1) % 128;
        n_irq   = (m_tsr & m_tier) != 0;
        n_upd   = load || tick;
        n_tsr   = (wr && a == 2) ? ((m_tsr & ~int'(PWDATA[2:0])) | set) : (m_tsr | set);
        @(posedge PCLK);
        #1;
        if (!PRESETn) begin
            model_reset();
        end else begin
            m_tcnt = cnt; m_en = n_en; m_presc = n_presc; m_irq = n_irq;
            m_upd = n_upd; m_tsr = n_tsr;
            if (wr) begin
                case (a)
                    0: m_tdr = int'(PWDATA);
                    1: begin
                        m_are = PWDATA[6]; m_down = PWDATA[5];
                        m_os = PWDATA[3]; m_cks = int'(PWDATA[2:0]);
                    end
                    4: m_tcmp = int'(PWDATA);
                    5: m_tier = int'(PWDATA[2:0]);
                    default: ;
                endcase
            end
        end
        check("irq", {31'd0, IRQ}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apb_write(input int a, input int d, output logic err_o);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 8'(a); PWDATA = 8'(d);
        cycle();
        PENABLE = 1;
        #1;
        err_o = PSLVERR;
        check("wr_slverr", {31'd0, PSLVERR}, {31'd0, model_err(a, 1'b1)});
        check("pready", {31'd0, PREADY}, 32'd1);
        cycle();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input int a, output logic [7:0] rd, output logic err_o);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'(a);
        cycle();
        PENABLE = 1;
        #1;
        rd    = PRDATA;
        err_o = PSLVERR;
        check("rd_data", {24'd0, PRDATA}, 32'(model_rd(a)));
        check("rd_slverr", {31'd0, PSLVERR}, {31'd0, model_err(a, 1'b0)});
        cycle();
        PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         rst_exp [6] = '{0, 0, 0, 0, 255, 0};

        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        model_reset();
        idle(3);
        PRESETn = 1;
        idle(1);

        // Reset values through the bus.
        for (int i = 0; i < 6; i++) begin
            apb_read(i, rd, er);
            check("reset_val", {24'd0, rd}, 32'(rst_exp[i]));
            check("reset_slverr", {31'd0, er}, 32'd0);
        end

        // Up count through the wrap.
        apb_write(0, 8'hFD, er);
        apb_write(1, 8'h90, er);
        apb_read(3, rd, er);
        check("up_fe", {24'd0, rd}, 32'hFE);
        apb_read(3, rd, er);
        check("up_wrap", {24'd0, rd}, 32'h00);
        apb_read(2, rd, er);
        check("ovf_set", {31'd0, rd[0]}, 32'd1);
        apb_write(1, 8'h00, er);
        apb_write(2, 8'h07, er);

        // Down one-shot with auto-reload and UNF interrupt.
        apb_write(0, 8'h02, er);
        apb_write(5, 8'h02, er);
        apb_write(1, 8'hF8, er);
        idle(6);
        check("irq_unf", {31'd0, IRQ}, 32'd1);
        apb_read(1, rd, er);
        check("os_en_clr", {31'd0, rd[4]}, 32'd0);
        apb_read(3, rd, er);
        check("os_reload", {24'd0, rd}, 32'd2);
        apb_read(2, rd, er);
        check("unf_set", {31'd0, rd[1]}, 32'd1);
        apb_write(2, 8'h07, er);
        apb_write(5, 8'h00, er);

        // Prescaled compare match, then W1C of CMF.
        apb_write(4, 8'h05, er);
        apb_write(0, 8'h03, er);
        apb_write(1, 8'h93, er);
        idle(24);
        apb_read(2, rd, er);
        check("cmf_set", {31'd0, rd[2]}, 32'd1);
        apb_write(2, 8'h04, er);
        apb_read(2, rd, er);
        check("cmf_clr", {31'd0, rd[2]}, 32'd0);
        apb_write(1, 8'h00, er);

        // Error responses.
        apb_write(3, 8'h55, er);
        check("err_wr_tcnt", {31'd0, er}, 32'd1);
        apb_read(7, rd, er);
        check("err_rd_7", {31'd0, er}, 32'd1);
        check("err_rd_data", {24'd0, rd}, 32'd0);
        apb_read(3, rd, er);

        // Set beats clear in the same edge.
        apb_write(2, 8'h07, er);
        apb_write(4, 8'h10, er);
        apb_write(0, 8'hFE, er);
        apb_write(1, 8'h90, er);
        apb_write(2, 8'h01, er);
        apb_read(2, rd, er);
        check("set_wins", {31'd0, rd[0]}, 32'd1);

        // Asynchronous reset mid-count.
        apb_write(5, 8'h07, er);
        idle(3);
        #2;
        PRESETn = 0;
        model_reset();
        #1;
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        idle(2);
        PRESETn = 1;
        idle(1);
        for (int i = 0; i < 6; i++) begin
            apb_read(i, rd, er);
            check("rst_mid_val", {24'd0, rd}, 32'(rst_exp[i]));
        end

        // Random traffic against the model.
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 3))
                0: apb_write(int'($urandom_range(0, 6)), int'($urandom_range(0, 255)), er);
                1: apb_write(1, int'($urandom_range(0, 255)) & 8'hFB, er);
                2: apb_read(int'($urandom_range(0, 7)), rd, er);
                default: idle(int'($urandom_range(1, 4)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
